de_ex_pipeline_reg: RTL
=======================

# de_ex_pipeline_reg

Decode-to-execute pipeline register for the RT core. Captures decode-stage operands and control into the EX stage each cycle. Applies the forwarding unit's WB-bypass selects to the scalar and vector operands. Turns decode stalls and branch flushes into bubbles, and feeds the registered write-back addresses and load/reduce flags back to the forwarding unit.

## Interface
- SDATA_W, 32, scalar operand width
- VDATA_W, 128, vector operand width (4 x 32-bit lanes)
- SADDR_W, 5, scalar register address width
- VADDR_W, 4, vector register address width
- CTRL_W, 16, opaque EX/MEM/WB control bundle width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- DE_valid  in  1  decode holds a real instruction
- DE_stall  in  1  load/reduce hazard from the forwarding unit
- MEM_stall  in  1  downstream hold; freeze the EX stage
- EX_flush  in  1  EX resolved a taken branch; kill the decode instruction
- DE_S1_data, DE_S2_data  in  SDATA_W  register-file scalar reads
- DE_V1_data, DE_V2_data  in  VDATA_W  register-file vector reads
- DE_EX_S1_select, DE_EX_S2_select, DE_EX_V1_select, DE_EX_V2_select  in  1  1 = take the WB data
- MEM_WB_Swb_data  in  SDATA_W  scalar write-back value
- MEM_WB_Vwb_data  in  VDATA_W  vector write-back value
- DE_Swb_address  in  SADDR_W  decode instruction's scalar destination
- DE_Vwb_address  in  VADDR_W  decode instruction's vector destination
- DE_MEM_read, DE_V_reduce  in  1  decode instruction flags
- DE_ctrl  in  CTRL_W  control bundle
- DE_imm  in  SDATA_W  immediate
- DE_ready  out  1  decode may advance; combinational
- EX_valid  out  1  registered valid
- EX_S1, EX_S2  out  SDATA_W  registered scalar operands
- EX_V1, EX_V2  out  VDATA_W  registered vector operands
- DE_EX_Swb_address  out  SADDR_W  registered scalar destination, to forwarding
- DE_EX_Vwb_address  out  VADDR_W  registered vector destination, to forwarding
- DE_EX_MEM_read, DE_EX_V_reduce  out  1  registered flags, to forwarding
- EX_ctrl  out  CTRL_W  registered control bundle
- EX_imm  out  SDATA_W  registered immediate
- bubble_count  out  16  saturating count of inserted bubbles

## Operation
- Operand mux: each operand is the WB data when its select is 1, otherwise the register-file data. The mux is applied at the capture edge.
- Per-edge action, highest priority first:
  - HOLD (MEM_stall=1): every EX register keeps its value. If EX_flush=1 in this cycle, set pending_flush.
  - BUBBLE (EX_flush=1, or pending_flush=1, or DE_stall=1, or DE_valid=0): load the bubble, then clear pending_flush.
  - LOAD: capture the muxed operands, DE_Swb_address, DE_Vwb_address, DE_MEM_read, DE_V_reduce, DE_ctrl and DE_imm. Set EX_valid=1.
- Bubble contents:
  - EX_valid=0, Swb/Vwb addresses=0 (register 0 means no write), MEM_read=0, V_reduce=0, ctrl=0.
  - Operands and imm hold their previous values, which keeps toggling down.
- bubble_count increments on a BUBBLE edge only when DE_valid=1, i.e. when a real instruction was stalled or killed. It saturates at 16'hFFFF.
- DE_ready = !MEM_stall && !DE_stall && !pending_flush.
- pending_flush is the only FSM state bit: IDLE -> PENDING on HOLD with EX_flush; PENDING -> IDLE on the first non-HOLD edge, which inserts a bubble.

## Timing
- Latency: 1 cycle from decode inputs to EX outputs.
- Reset, asynchronous: every registered output is 0, including EX_valid, all addresses and flags, operands, ctrl, imm and bubble_count. pending_flush is 0.
- DE_ready tracks its inputs combinationally. During reset it evaluates to !MEM_stall && !DE_stall.
- A DE_stall cycle yields exactly one bubble. Decode re-presents the same instruction the next cycle, with selects recomputed against the new MEM_WB stage.
- With MEM_stall and DE_stall both high, HOLD wins and no bubble is inserted.
- With EX_flush and DE_stall both high, a single bubble is inserted and counted once.
- Reset asserted mid-HOLD or mid-PENDING returns the block to the reset state immediately, and pending_flush is lost.
- bubble_count at 16'hFFFF stays at 16'hFFFF.

## Test plan
- Reset, then DE_valid=1 with S1=32'h11, S2=32'h22, V1=128'hA, selects 0 -> next edge EX_valid=1, EX_S1=32'h11, EX_S2=32'h22, EX_V1=128'hA.
- DE_EX_S1_select=1, DE_EX_V2_select=1, MEM_WB_Swb_data=32'hBEEF, MEM_WB_Vwb_data=128'h5 -> EX_S1=32'hBEEF and EX_V2=128'h5; the other operands come from the register file.
- Load with DE_Swb_address=7, DE_MEM_read=1, then DE_stall=1 for one cycle -> EX_valid=0, DE_EX_Swb_address=0, DE_EX_MEM_read=0, bubble_count=1, DE_ready=0 during the stall.
- MEM_stall=1 for 3 cycles with EX_flush pulsed in cycle 2 -> EX outputs frozen for all 3 cycles, DE_ready=0. On the first edge after release: EX_valid=0 and bubble_count +1.
- Assert rst asynchronously between edges while EX_valid=1 and bubble_count=5 -> all outputs 0 immediately, without waiting for a clock edge.
- Force 65536 stall bubbles -> bubble_count reaches 16'hFFFF and stays there.

Source files
------------

// File: rtl/de_ex_pipeline_reg.sv
// Decode-to-execute pipeline register: applies WB-bypass selects to the operands,
// turns stalls and flushes into bubbles, and reports EX destinations to forwarding.
module de_ex_pipeline_reg #(
    parameter int SDATA_W = 32,
    parameter int VDATA_W = 128,
    parameter int SADDR_W = 5,
    parameter int VADDR_W = 4,
    parameter int CTRL_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               DE_valid,
    input  logic               DE_stall,
    input  logic               MEM_stall,
    input  logic               EX_flush,
    input  logic [SDATA_W-1:0] DE_S1_data,
    input  logic [SDATA_W-1:0] DE_S2_data,
    input  logic [VDATA_W-1:0] DE_V1_data,
    input  logic [VDATA_W-1:0] DE_V2_data,
    input  logic               DE_EX_S1_select,
    input  logic               DE_EX_S2_select,
    input  logic               DE_EX_V1_select,
    input  logic               DE_EX_V2_select,
    input  logic [SDATA_W-1:0] MEM_WB_Swb_data,
    input  logic [VDATA_W-1:0] MEM_WB_Vwb_data,
    input  logic [SADDR_W-1:0] DE_Swb_address,
    input  logic [VADDR_W-1:0] DE_Vwb_address,
    input  logic               DE_MEM_read,
    input  logic               DE_V_reduce,
    input  logic [CTRL_W-1:0]  DE_ctrl,
    input  logic [SDATA_W-1:0] DE_imm,
    output logic               DE_ready,
    output logic               EX_valid,
    output logic [SDATA_W-1:0] EX_S1,
    output logic [SDATA_W-1:0] EX_S2,
    output logic [VDATA_W-1:0] EX_V1,
    output logic [VDATA_W-1:0] EX_V2,
    output logic [SADDR_W-1:0] DE_EX_Swb_address,
    output logic [VADDR_W-1:0] DE_EX_Vwb_address,
    output logic               DE_EX_MEM_read,
    output logic               DE_EX_V_reduce,
    output logic [CTRL_W-1:0]  EX_ctrl,
    output logic [SDATA_W-1:0] EX_imm,
    output logic [15:0]        bubble_count
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } flushState_t;

    flushState_t        r_flushState;
    logic               r_valid;
    logic [SDATA_W-1:0] r_s1;
    logic [SDATA_W-1:0] r_s2;
    logic [VDATA_W-1:0] r_v1;
    logic [VDATA_W-1:0] r_v2;
    logic [SADDR_W-1:0] r_swbAddr;
    logic [VADDR_W-1:0] r_vwbAddr;
    logic               r_memRead;
    logic               r_vReduce;
    logic [CTRL_W-1:0]  r_ctrl;
    logic [SDATA_W-1:0] r_imm;
    logic [15:0]        r_bubbleCount;

    logic               w_hold;
    logic               w_bubble;
    logic [SDATA_W-1:0] w_s1;
    logic [SDATA_W-1:0] w_s2;
    logic [VDATA_W-1:0] w_v1;
    logic [VDATA_W-1:0] w_v2;

    assign w_hold   = MEM_stall;
    assign w_bubble = EX_flush || (r_flushState == PENDING) || DE_stall || !DE_valid;

    assign w_s1 = DE_EX_S1_select ? MEM_WB_Swb_data : DE_S1_data;
    assign w_s2 = DE_EX_S2_select ? MEM_WB_Swb_data : DE_S2_data;
    assign w_v1 = DE_EX_V1_select ? MEM_WB_Vwb_data : DE_V1_data;
    assign w_v2 = DE_EX_V2_select ? MEM_WB_Vwb_data : DE_V2_data;

    assign DE_ready = !MEM_stall && !DE_stall && (r_flushState == IDLE);

    // A flush that arrives while EX is frozen is remembered and becomes a bubble on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flushState  <= IDLE;
            r_valid       <= 1'b0;
            r_s1          <= '0;
            r_s2          <= '0;
            r_v1          <= '0;
            r_v2          <= '0;
            r_swbAddr     <= '0;
            r_vwbAddr     <= '0;
            r_memRead     <= 1'b0;
            r_vReduce     <= 1'b0;
            r_ctrl        <= '0;
            r_imm         <= '0;
            r_bubbleCount <= '0;
        end else if (w_hold) begin
            if (EX_flush) begin
                r_flushState <= PENDING;
            end
        end else if (w_bubble) begin
            // Operands and imm are left alone so the datapath does not toggle on bubbles.
            r_flushState <= IDLE;
            r_valid      <= 1'b0;
            r_swbAddr    <= '0;
            r_vwbAddr    <= '0;
            r_memRead    <= 1'b0;
            r_vReduce    <= 1'b0;
            r_ctrl       <= '0;
            if (DE_valid && (r_bubbleCount != 16'hFFFF)) begin
                r_bubbleCount <= r_bubbleCount + 16'd1;
            end
        end else begin
            r_valid   <= 1'b1;
            r_s1      <= w_s1;
            r_s2      <= w_s2;
            r_v1      <= w_v1;
            r_v2      <= w_v2;
            r_swbAddr <= DE_Swb_address;
            r_vwbAddr <= DE_Vwb_address;
            r_memRead <= DE_MEM_read;
            r_vReduce <= DE_V_reduce;
            r_ctrl    <= DE_ctrl;
            r_imm     <= DE_imm;
        end
    end

    assign EX_valid          = r_valid;
    assign EX_S1             = r_s1;
    assign EX_S2             = r_s2;
    assign EX_V1             = r_v1;
    assign EX_V2             = r_v2;
    assign DE_EX_Swb_address = r_swbAddr;
    assign DE_EX_Vwb_address = r_vwbAddr;
    assign DE_EX_MEM_read    = r_memRead;
    assign DE_EX_V_reduce    = r_vReduce;
    assign EX_ctrl           = r_ctrl;
    assign EX_imm            = r_imm;
    assign bubble_count      = r_bubbleCount;

endmodule
